// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder sequencer with one shared BCD digit stage
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   op_a,
   input  logic [4*DIGITS-1:0]   op_b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state;
   logic [IDX_W-1:0]      idx;
   logic                  carry;
   logic [4*DIGITS-1:0]   a_lat;
   logic [4*DIGITS-1:0]   b_lat;
   logic [4*DIGITS-1:0]   sum_reg;
   logic                  cout_reg;
   logic                  err_reg;

   logic [3:0]            dig_a;
   logic [3:0]            dig_b;
   logic [4:0]            raw;
   logic                  corr;
   logic [3:0]            dig_out;
   logic                  bad_digit;
   logic [4*DIGITS-1:0]   sum_next;

   // select the current operand digits from the latched copies
   always_comb begin
      dig_a = 4'd0;
      dig_b = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == i[IDX_W-1:0]) begin
            dig_a = a_lat[4*i +: 4];
            dig_b = b_lat[4*i +: 4];
         end
      end
   end

   // shared one-digit BCD adder: binary add, then +6 when above 9 or on 4-bit carry-out
   always_comb begin
      raw       = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry};
      corr      = raw[4] | (raw[3] & raw[2]) | (raw[3] & raw[1]);
      dig_out   = raw[3:0] + (corr ? 4'd6 : 4'd0);
      bad_digit = (dig_a > 4'd9) | (dig_b > 4'd9);
   end

   // splice the corrected digit into the result at the current index
   always_comb begin
      sum_next = sum_reg;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == i[IDX_W-1:0]) begin
            sum_next[4*i +: 4] = dig_out;
         end
      end
   end

   // sequencer: accept in IDLE, one digit per edge in RUN, single-cycle DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_lat    <= '0;
         b_lat    <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_lat    <= op_a;
                  b_lat    <= op_b;
                  carry    <= cin;
                  idx      <= '0;
                  sum_reg  <= '0;
                  cout_reg <= 1'b0;
                  err_reg  <= 1'b0;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_reg <= sum_next;
               carry   <= corr;
               err_reg <= err_reg | bad_digit;
               if (idx == IDX_LAST) begin
                  cout_reg <= corr;
                  state    <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_RUN) || (state == ST_DONE);
   assign done = (state == ST_DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - bench for bcd_serial_add_ctrl (DIGITS=4 and DIGITS=1)
module tb_bcd_serial_add_ctrl;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] s;
      logic        c;
      logic        e;
   } vec_t;

   typedef struct {
      int          id;
      logic [15:0] s;
      logic        c;
      logic        e;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start4, cin4, busy4, done4, cout4, err4;
   logic [15:0] a4, b4, sum4;
   logic        start1, cin1, busy1, done1, cout1, err1;
   logic [3:0]  a1, b1, sum1;

   int   n_cmp;
   int   n_bad;
   int   done_cnt;
   exp_t sbq[$];
   vec_t tbl[14];

   bcd_serial_add_ctrl #(.DIGITS(4)) u_dut4 (
      .clk(clk), .reset(rst), .start(start4), .op_a(a4), .op_b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4)
   );

   bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
      .clk(clk), .reset(rst), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference digit-serial model used for the random vectors
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                 output logic [15:0] s, output logic co, output logic e);
      logic       c;
      logic [3:0] da, db;
      logic [4:0] t;
      logic       k;
      c = ci;
      e = 1'b0;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         da = a[4*i +: 4];
         db = b[4*i +: 4];
         t  = {1'b0, da} + {1'b0, db} + {4'd0, c};
         k  = (t > 5'd9);
         s[4*i +: 4] = k ? (t[3:0] + 4'd6) : t[3:0];
         e  = e | (da > 4'd9) | (db > 4'd9);
         c  = k;
      end
      co = c;
   endfunction

   // scoreboard: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done4) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            chk($sformatf("op%0d_sum", x.id), {16'd0, sum4}, {16'd0, x.s});
            chk($sformatf("op%0d_cout", x.id), {31'd0, cout4}, {31'd0, x.c});
            chk($sformatf("op%0d_err", x.id), {31'd0, err4}, {31'd0, x.e});
         end
      end
   end

   task automatic run4(input int id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic ec, input logic ee);
      int  lat;
      bit  got;
      exp_t x;
      @(negedge clk);
      a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
      @(posedge clk);
      x.id = id; x.s = es; x.c = ec; x.e = ee;
      sbq.push_back(x);
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~a; b4 = ~b; cin4 = ~ci;
      lat = 0;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) chk($sformatf("op%0d_busy", id), {31'd0, busy4}, 32'd1);
         if (done4) begin
            got = 1;
            break;
         end
      end
      chk($sformatf("op%0d_done_seen", id), {31'd0, got}, 32'd1);
      chk($sformatf("op%0d_latency", id), lat, 32'd4);
      @(posedge clk);
   endtask

   task automatic run1(input string nm, input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] es, input logic ec);
      int lat;
      bit got;
      @(negedge clk);
      a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      a1 = 4'd0; b1 = 4'd0;
      lat = 0;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done1) begin
            got = 1;
            break;
         end
      end
      chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
      chk({nm, "_latency"}, lat, 32'd1);
      chk({nm, "_sum"}, {28'd0, sum1}, {28'd0, es});
      chk({nm, "_cout"}, {31'd0, cout1}, {31'd0, ec});
      chk({nm, "_err"}, {31'd0, err1}, 32'd0);
      @(posedge clk);
   endtask

   initial begin
      int base;
      bit seen;
      n_cmp = 0; n_bad = 0; done_cnt = 0;
      rst = 1'b1;
      start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
      start1 = 0; a1 = '0; b1 = '0; cin1 = 0;

      tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
      tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      tbl[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b1};
      tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{16'h0F00, 16'h0000, 1'b0, 16'h1500, 1'b0, 1'b1};
      tbl[7] = '{16'h4567, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0};
      for (int i = 8; i < 14; i++) begin
         for (int d = 0; d < 4; d++) begin
            tbl[i].a[4*d +: 4] = 4'($urandom_range(0, 9));
            tbl[i].b[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         tbl[i].ci = 1'($urandom_range(0, 1));
         model(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c, tbl[i].e);
      end

      #12;
      chk("rst_busy", {31'd0, busy4}, 32'd0);
      chk("rst_done", {31'd0, done4}, 32'd0);
      chk("rst_sum", {16'd0, sum4}, 32'd0);
      chk("rst_cout", {31'd0, cout4}, 32'd0);
      chk("rst_err", {31'd0, err4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run4(i, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c, tbl[i].e);
      end

      // start held high through RUN and DONE with changing operands
      base = done_cnt;
      @(negedge clk);
      a4 = 16'h2468; b4 = 16'h1357; cin4 = 1'b0; start4 = 1'b1;
      @(posedge clk);
      sbq.push_back('{100, 16'h3825, 1'b0, 1'b0});
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
         if (done4) begin
            seen = 1;
            break;
         end
      end
      chk("hold_done_seen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      chk("hold_no_accept_in_done", {31'd0, busy4}, 32'd0);
      repeat (8) @(posedge clk);
      chk("hold_one_done", done_cnt - base, 32'd1);

      // asynchronous reset in the second RUN cycle
      @(negedge clk);
      a4 = 16'h000A; b4 = 16'h0005; cin4 = 1'b0; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_abort_sum", {16'd0, sum4}, 32'h0005);
      chk("pre_abort_err", {31'd0, err4}, 32'd1);
      base = done_cnt;
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy4}, 32'd0);
      chk("abort_done", {31'd0, done4}, 32'd0);
      chk("abort_sum", {16'd0, sum4}, 32'd0);
      chk("abort_cout", {31'd0, cout4}, 32'd0);
      chk("abort_err", {31'd0, err4}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      chk("abort_no_done", done_cnt - base, 32'd0);
      run4(200, 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

      // single-digit configuration
      run1("d1_7p8c1", 4'h7, 4'h8, 1'b1, 4'h6, 1'b1);
      run1("d1_9p9c1", 4'h9, 4'h9, 1'b1, 4'h9, 1'b1);
      run1("d1_2p3c0", 4'h2, 4'h3, 1'b0, 4'h5, 1'b0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
